bp_update_scheduler: RTL and testbench

- Sequences all writes into the branch predictor's BHT/PHT tables, which have a single write port.
- After reset, or on request, it walks every table index and writes it to zero. Until that walk finishes, it masks predictions.
- In normal operation it accepts up to two resolved-branch updates per cycle from the E stage, master before slave, and serialises them into one table write per cycle through a small in-order queue.
- It back-pressures the E stage when the queue cannot absorb a worst-case pair.

---
 rtl/bp_update_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// Single-port write sequencer for the branch predictor BHT/PHT: clears every index after reset
// or on request, then serialises up to two resolved-branch updates per cycle into one write per cycle.
module bp_update_scheduler #(
   parameter int BHT_DEPTH = 10,
   parameter int PHT_DEPTH = 6,
   parameter int QDEPTH    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_req,
   input  logic                 upd1_valid,
   input  logic [31:0]          upd1_pc,
   input  logic                 upd1_take,
   input  logic                 upd2_valid,
   input  logic [31:0]          upd2_pc,
   input  logic                 upd2_take,
   output logic                 upd_stall,
   output logic                 tbl_we,
   output logic                 tbl_clr,
   output logic [BHT_DEPTH-1:0] tbl_idx,
   output logic                 tbl_take,
   output logic                 pred_mask,
   output logic                 ovf_err
);

   localparam int WALK_W = (BHT_DEPTH > PHT_DEPTH) ? BHT_DEPTH : PHT_DEPTH;
   localparam int QW     = $clog2(QDEPTH);
   localparam int EW     = BHT_DEPTH + 1;

   localparam logic [WALK_W-1:0] WALK_ONE  = WALK_W'(1'b1);
   localparam logic [WALK_W-1:0] WALK_LAST = '1;
   localparam logic [QW-1:0]     PTR_ONE   = QW'(1'b1);
   localparam logic [QW:0]       CNT_ZERO  = '0;
   localparam logic [QW:0]       CNT_ONE   = (QW+1)'(1'b1);
   localparam logic [QW:0]       CNT_TWO   = (QW+1)'(2'd2);
   localparam logic [QW:0]       STALL_TH  = (QW+1)'(QDEPTH - 2);

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_r;
   logic [WALK_W-1:0]   walk_cnt_r;
   logic [QW-1:0]       rd_ptr_r;
   logic [QW-1:0]       wr_ptr_r;
   logic [QW:0]         count_r;
   logic [EW-1:0]       queue_r [QDEPTH];
   logic                ovf_err_r;

   logic [EW-1:0]       entry1_s;
   logic [EW-1:0]       entry2_s;
   logic [EW-1:0]       head_s;
   logic                stall_s;
   logic                accept_s;
   logic                push1_s;
   logic                push2_s;
   logic                pop_s;
   logic [QW:0]         push_n_s;
   logic [QW:0]         pop_n_s;
   logic                wr_en0_s;
   logic                wr_en1_s;
   logic [EW-1:0]       wr_data0_s;
   logic [EW-1:0]       wr_data1_s;
   logic [QW-1:0]       wr_ptr_p1_s;
   logic                ovf_hit_s;
   logic                unused_pc_s;

   assign entry1_s    = {upd1_pc[BHT_DEPTH+1:2], upd1_take};
   assign entry2_s    = {upd2_pc[BHT_DEPTH+1:2], upd2_take};
   assign head_s      = queue_r[rd_ptr_r];
   assign wr_ptr_p1_s = wr_ptr_r + PTR_ONE;
   assign unused_pc_s = ^{upd1_pc[31:BHT_DEPTH+2], upd1_pc[1:0],
                          upd2_pc[31:BHT_DEPTH+2], upd2_pc[1:0]};

   // Stall is taken from registered occupancy so a full pair always fits when it is low.
   always_comb begin
      stall_s   = (state_r == RUN) && (count_r > STALL_TH);
      accept_s  = (state_r == RUN) && !stall_s && !clear_req;
      push1_s   = accept_s && upd1_valid;
      push2_s   = accept_s && upd2_valid;
      pop_s     = (state_r == RUN) && (count_r != CNT_ZERO);
      ovf_hit_s = stall_s && (upd1_valid || upd2_valid);
   end

   // Program-order slot assignment: master takes the first free slot when both are valid.
   always_comb begin
      wr_en0_s   = 1'b0;
      wr_en1_s   = 1'b0;
      wr_data0_s = '0;
      wr_data1_s = '0;
      push_n_s   = CNT_ZERO;
      if (push1_s && push2_s) begin
         wr_en0_s   = 1'b1;
         wr_en1_s   = 1'b1;
         wr_data0_s = entry1_s;
         wr_data1_s = entry2_s;
         push_n_s   = CNT_TWO;
      end else if (push1_s) begin
         wr_en0_s   = 1'b1;
         wr_data0_s = entry1_s;
         push_n_s   = CNT_ONE;
      end else if (push2_s) begin
         wr_en0_s   = 1'b1;
         wr_data0_s = entry2_s;
         push_n_s   = CNT_ONE;
      end else begin
         push_n_s   = CNT_ZERO;
      end
      if (pop_s) begin
         pop_n_s = CNT_ONE;
      end else begin
         pop_n_s = CNT_ZERO;
      end
   end

   // Control FSM, clear walk and update queue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= INIT;
         walk_cnt_r <= '0;
         rd_ptr_r   <= '0;
         wr_ptr_r   <= '0;
         count_r    <= '0;
         ovf_err_r  <= 1'b0;
         for (int i = 0; i < QDEPTH; i++) begin
            queue_r[i] <= '0;
         end
      end else begin
         ovf_err_r <= ovf_err_r | ovf_hit_s;
         if (clear_req) begin
            state_r    <= INIT;
            walk_cnt_r <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
         end else begin
            case (state_r)
               INIT: begin
                  walk_cnt_r <= walk_cnt_r + WALK_ONE;
                  if (walk_cnt_r == WALK_LAST) begin
                     state_r <= RUN;
                  end
               end
               RUN: begin
                  if (wr_en0_s) begin
                     queue_r[wr_ptr_r] <= wr_data0_s;
                  end
                  if (wr_en1_s) begin
                     queue_r[wr_ptr_p1_s] <= wr_data1_s;
                  end
                  wr_ptr_r <= wr_ptr_r + push_n_s[QW-1:0];
                  rd_ptr_r <= rd_ptr_r + pop_n_s[QW-1:0];
                  count_r  <= count_r + push_n_s - pop_n_s;
               end
               default: begin
                  state_r    <= INIT;
                  walk_cnt_r <= '0;
               end
            endcase
         end
      end
   end

   // Table write port and prediction mask decode.
   always_comb begin
      tbl_we    = 1'b0;
      tbl_clr   = 1'b0;
      tbl_idx   = '0;
      tbl_take  = 1'b0;
      pred_mask = 1'b1;
      case (state_r)
         INIT: begin
            tbl_we    = 1'b1;
            tbl_clr   = 1'b1;
            tbl_idx   = walk_cnt_r[BHT_DEPTH-1:0];
            pred_mask = 1'b1;
         end
         RUN: begin
            pred_mask = 1'b0;
            if (count_r != CNT_ZERO) begin
               tbl_we   = 1'b1;
               tbl_idx  = head_s[EW-1:1];
               tbl_take = head_s[0];
            end else begin
               tbl_we   = 1'b0;
            end
         end
         default: begin
            pred_mask = 1'b1;
         end
      endcase
   end

   assign upd_stall = stall_s;
   assign ovf_err   = ovf_err_r;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler (BHT_DEPTH=4, PHT_DEPTH=6, QDEPTH=4): clear walk,
// single/paired updates, stall and drain, overflow flag, clear_req and asynchronous reset.
module tb_bp_update_scheduler;

   logic       clk;
   logic       rst;
   logic       clear_req;
   logic       upd1_valid;
   logic [31:0] upd1_pc;
   logic       upd1_take;
   logic       upd2_valid;
   logic [31:0] upd2_pc;
   logic       upd2_take;
   logic       upd_stall;
   logic       tbl_we;
   logic       tbl_clr;
   logic [3:0] tbl_idx;
   logic       tbl_take;
   logic       pred_mask;
   logic       ovf_err;

   int n_assert;
   int n_fail;

   logic [9:0] obs_s;
   assign obs_s = {tbl_we, tbl_clr, tbl_idx, tbl_take, pred_mask, upd_stall, ovf_err};

   bp_update_scheduler #(
      .BHT_DEPTH(4),
      .PHT_DEPTH(6),
      .QDEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clear_req(clear_req),
      .upd1_valid(upd1_valid),
      .upd1_pc(upd1_pc),
      .upd1_take(upd1_take),
      .upd2_valid(upd2_valid),
      .upd2_pc(upd2_pc),
      .upd2_take(upd2_take),
      .upd_stall(upd_stall),
      .tbl_we(tbl_we),
      .tbl_clr(tbl_clr),
      .tbl_idx(tbl_idx),
      .tbl_take(tbl_take),
      .pred_mask(pred_mask),
      .ovf_err(ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] mk(input logic we, input logic clr, input logic [3:0] idx,
                                     input logic take, input logic pm, input logic st,
                                     input logic ov);
      return {we, clr, idx, take, pm, st, ov};
   endfunction

   // Vector order: {we, clr, idx[3:0], take, pred_mask, stall, ovf_err}
   task automatic chk(input string tag, input logic [9:0] exp);
      n_assert++;
      assert (obs_s === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b required %b", tag, obs_s, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic set_upd(input logic v1, input logic [31:0] pc1, input logic t1,
                          input logic v2, input logic [31:0] pc2, input logic t2);
      upd1_valid = v1; upd1_pc = pc1; upd1_take = t1;
      upd2_valid = v2; upd2_pc = pc2; upd2_take = t2;
   endtask

   task automatic walk_and_idle(input string tag);
      for (int i = 0; i < 64; i++) begin
         chk(tag, mk(1'b1, 1'b1, 4'(i), 1'b0, 1'b1, 1'b0, 1'b0));
         next_cyc();
      end
      chk("idle_after_walk", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      rst        = 1'b0;
      clear_req  = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Reset state, then the 64-entry clear walk with truncated index.
      next_cyc();
      chk("reset", mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      rst = 1'b1;
      walk_and_idle("walk1");

      // Single master update: one write in N+1, idle in N+2.
      set_upd(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b0);
      next_cyc();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("single_n1", mk(1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0));
      next_cyc();
      chk("single_n2", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Pair: master then slave.
      set_upd(1'b1, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0024, 1'b1);
      next_cyc();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("pair_n1", mk(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0));
      next_cyc();
      chk("pair_n2", mk(1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0));
      next_cyc();
      chk("pair_n3", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Back-to-back pairs fill to 3 and stall; E stage holds, queue drains in order.
      set_upd(1'b1, 32'h0000_0030, 1'b1, 1'b1, 32'h0000_0034, 1'b0);
      next_cyc();
      set_upd(1'b1, 32'h0000_0038, 1'b1, 1'b1, 32'h0000_003C, 1'b1);
      chk("fill_c2", mk(1'b1, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0));
      next_cyc();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("fill_c3_stall", mk(1'b1, 1'b0, 4'd13, 1'b0, 1'b0, 1'b1, 1'b0));
      next_cyc();
      chk("drain_c2", mk(1'b1, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0));
      next_cyc();
      chk("drain_c1", mk(1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0));
      next_cyc();
      chk("drain_c0", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Update driven while stalled: flag sets and sticks, entry (idx 10) never written.
      set_upd(1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0004, 1'b1);
      next_cyc();
      set_upd(1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_000C, 1'b1);
      chk("ovf_fill2", mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      next_cyc();
      set_upd(1'b1, 32'h0000_0028, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("ovf_stall", mk(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0));
      next_cyc();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("ovf_set", mk(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1));
      next_cyc();
      chk("ovf_drain", mk(1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1));
      next_cyc();
      chk("ovf_empty", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
      next_cyc();
      chk("ovf_sticky", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));

      // clear_req with 3 queued: flush and restart walk.
      set_upd(1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0014, 1'b1);
      next_cyc();
      set_upd(1'b1, 32'h0000_0018, 1'b0, 1'b1, 32'h0000_001C, 1'b1);
      chk("clr_fill2", mk(1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1));
      next_cyc();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      clear_req = 1'b1;
      chk("clr_fill3", mk(1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1));
      next_cyc();
      clear_req = 1'b0;
      chk("clr_init0", mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1));
      next_cyc();
      chk("clr_init1", mk(1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1));
      next_cyc();
      next_cyc();
      chk("clr_init3", mk(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1));

      // clear_req during the walk restarts it.
      clear_req = 1'b1;
      next_cyc();
      clear_req = 1'b0;
      chk("restart0", mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1));
      next_cyc();
      chk("restart1", mk(1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1));

      // Asynchronous reset mid-walk, away from any clock edge.
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst", mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      next_cyc();
      rst = 1'b1;
      walk_and_idle("walk2");
      next_cyc();
      chk("idle_final", mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
